// File: rtl/instruction_fetch_controller_if.sv
// Fetch-to-decode handshake: fetch side is master, decode side is slave.
// The payload is {Out_PC, Out_Instruction}; a transfer occurs on Out_Valid & Out_Ready.
interface instruction_fetch_controller_if;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_Instruction;
  logic [63:0] Out_PC;

  modport master (output Out_Valid, output Out_Instruction, output Out_PC, input Out_Ready);
  modport slave  (input Out_Valid, input Out_Instruction, input Out_PC, output Out_Ready);
endinterface

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, prefetches words into a small FIFO and
// hands them to decode. Optional FETCH_PERF_COUNT_EN adds push and stall counters.
//
// state | meaning
// IDLE  | no fetching; waiting for Fetch_Enable
// FETCH | pushing {fetch_pc, Instruction} whenever the buffer has room
// HALT  | stopped on an illegal fetch address; only Redirect or reset leaves
module instruction_fetch_controller #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 16,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Fetch_Enable,
  output logic [63:0] Init_Address,
  input  logic [31:0] Instruction,
  input  logic        Redirect,
  input  logic [63:0] Redirect_Target,
  output logic        Fault,
`ifdef FETCH_PERF_COUNT_EN
  output logic [31:0] Fetch_Count,
  output logic [31:0] Stall_Count,
`endif
  instruction_fetch_controller_if.master out_if
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(BUF_DEPTH);
  localparam logic [64:0]    MEM_LIMIT = 65'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t           state;
  logic [63:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [63:0]      buf_pc    [BUF_DEPTH];
  logic [31:0]      buf_instr [BUF_DEPTH];

  logic pop;
  logic push;
  logic addr_illegal;
  logic has_space;

  // 65-bit add so an address near 2^64 cannot wrap past the range check
  always_comb begin
    addr_illegal = (({1'b0, fetch_pc} + 65'd3) >= MEM_LIMIT) || (fetch_pc[1:0] != 2'b00);
    pop          = out_if.Out_Valid & out_if.Out_Ready;
    has_space    = (count != DEPTH_CNT) || pop;
    push         = (state == FETCH) && Fetch_Enable && !Redirect && !addr_illegal && has_space;
  end

  assign Init_Address           = fetch_pc;
  assign out_if.Out_Valid       = (count != '0);
  assign out_if.Out_Instruction = buf_instr[rd_ptr];
  assign out_if.Out_PC          = buf_pc[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      Fault    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (Redirect) begin
      state    <= Fetch_Enable ? FETCH : IDLE;
      fetch_pc <= Redirect_Target;
      Fault    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE:    if (Fetch_Enable) state <= FETCH;
        FETCH: begin
          if (!Fetch_Enable) begin
            state <= IDLE;
          end else if (addr_illegal) begin
            state <= HALT;
            Fault <= 1'b1;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase

      if (push) begin
        buf_pc[wr_ptr]    <= fetch_pc;
        buf_instr[wr_ptr] <= Instruction;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        fetch_pc          <= fetch_pc + 64'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  // Counters survive Redirect; only reset clears them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Fetch_Count <= '0;
      Stall_Count <= '0;
    end else begin
      if (push) Fetch_Count <= Fetch_Count + 32'd1;
      if (out_if.Out_Valid && !out_if.Out_Ready) Stall_Count <= Stall_Count + 32'd1;
    end
  end
`endif

endmodule
